// File: rtl/memory_port_arbiter_pkg.sv
// memory_port_arbiter_pkg: shared byte/bus types and port identifiers for the memory front end
// Contents: DEFAULT_TYPE byte, MEMORY_FLAG_TYPE memory command, MEMORY_PORT_TYPE requester id, MEMSIZE.
package memory_port_arbiter_pkg;
    typedef logic [7:0] DEFAULT_TYPE;
    typedef enum logic [1:0] {MEMORY_NONE, MEMORY_READ, MEMORY_WRITE} MEMORY_FLAG_TYPE;
    typedef enum logic {PORT_FETCH, PORT_DATA} MEMORY_PORT_TYPE;
    localparam int MEMSIZE = 256;
endpackage

// File: rtl/memory_port_arbiter_if.sv
// memory_port_arbiter_if: fetch/data request-response channels plus the memory bus
// Modports: slave = arbiter side (drives ready/response/memory command), master = CPU/memory side.
interface memory_port_arbiter_if;
    import memory_port_arbiter_pkg::*;
    logic            fetch_req_valid;
    logic            fetch_req_ready;
    DEFAULT_TYPE     fetch_addr;
    logic            fetch_rsp_valid;
    logic            fetch_rsp_ready;
    DEFAULT_TYPE     fetch_rsp_data;
    logic            data_req_valid;
    logic            data_req_ready;
    logic            data_req_write;
    DEFAULT_TYPE     data_addr;
    DEFAULT_TYPE     data_wdata;
    logic            data_rsp_valid;
    logic            data_rsp_ready;
    DEFAULT_TYPE     data_rsp_data;
    MEMORY_FLAG_TYPE mem_ctrl;
    DEFAULT_TYPE     mem_addr;
    DEFAULT_TYPE     mem_write;
    DEFAULT_TYPE     mem_read;
    modport slave (
        input  fetch_req_valid, fetch_addr, fetch_rsp_ready,
        input  data_req_valid, data_req_write, data_addr, data_wdata, data_rsp_ready, mem_read,
        output fetch_req_ready, fetch_rsp_valid, fetch_rsp_data,
        output data_req_ready, data_rsp_valid, data_rsp_data, mem_ctrl, mem_addr, mem_write
    );
    modport master (
        output fetch_req_valid, fetch_addr, fetch_rsp_ready,
        output data_req_valid, data_req_write, data_addr, data_wdata, data_rsp_ready, mem_read,
        input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_data,
        input  data_req_ready, data_rsp_valid, data_rsp_data, mem_ctrl, mem_addr, mem_write
    );
endinterface

// File: rtl/memory_response_slot.sv
// memory_response_slot: one-entry response buffer, loaded from memory read data, popped by the consumer
// Ports: CLOCK, RESET (sync, active-high), load/load_data in, pop in, valid/data out.
module memory_response_slot
    import memory_port_arbiter_pkg::*;
(
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        load,
    input  DEFAULT_TYPE load_data,
    input  logic        pop,
    output logic        valid,
    output DEFAULT_TYPE data
);
    // The arbiter never loads a full slot, so load simply overrides pop.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            valid <= load ? 1'b1 : valid & ~pop;
            data  <= load ? load_data : data;
        end
    end
endmodule

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: round-robin front end sharing one single-port memory between fetch and data ports
// Ports: CLOCK, RESET (sync, active-high), bus (memory_port_arbiter_if.slave: both request/response channels and memory bus).
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    memory_port_arbiter_if.slave   bus
);
    logic            pend_valid;
    MEMORY_PORT_TYPE pend_port;
    MEMORY_PORT_TYPE last_grant;
    logic            fetch_elig, data_elig, grant_fetch, grant_data, data_rd, read_grant;
    // A read is only eligible when its port has nothing in flight and an empty slot,
    // so a capture can never land on a full slot. Nothing is granted during reset.
    always_comb begin
        fetch_elig  = ~RESET & bus.fetch_req_valid & ~bus.fetch_rsp_valid
                    & ~(pend_valid & pend_port == PORT_FETCH);
        data_elig   = ~RESET & bus.data_req_valid & (bus.data_req_write
                    | (~bus.data_rsp_valid & ~(pend_valid & pend_port == PORT_DATA)));
        grant_data  = data_elig & (~fetch_elig | last_grant == PORT_FETCH);
        grant_fetch = fetch_elig & ~grant_data;
        data_rd     = grant_data & ~bus.data_req_write;
        read_grant  = grant_fetch | data_rd;
    end
    assign bus.fetch_req_ready = grant_fetch;
    assign bus.data_req_ready  = grant_data;
    assign bus.mem_ctrl  = read_grant ? MEMORY_READ : grant_data ? MEMORY_WRITE : MEMORY_NONE;
    assign bus.mem_addr  = grant_data ? bus.data_addr : grant_fetch ? bus.fetch_addr : '0;
    assign bus.mem_write = (grant_data & bus.data_req_write) ? bus.data_wdata : '0;
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            pend_valid <= 1'b0;
            pend_port  <= PORT_FETCH;
            last_grant <= DATA_FIRST ? PORT_FETCH : PORT_DATA;
        end else begin
            pend_valid <= read_grant;
            if (read_grant)
                pend_port <= data_rd ? PORT_DATA : PORT_FETCH;
            if (grant_fetch | grant_data)
                last_grant <= grant_data ? PORT_DATA : PORT_FETCH;
        end
    end
    // Memory returns read data one cycle after the address; route it to the issuing port.
    memory_response_slot u_fetch_slot (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .load      (pend_valid & pend_port == PORT_FETCH),
        .load_data (bus.mem_read),
        .pop       (bus.fetch_rsp_ready),
        .valid     (bus.fetch_rsp_valid),
        .data      (bus.fetch_rsp_data)
    );
    memory_response_slot u_data_slot (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .load      (pend_valid & pend_port == PORT_DATA),
        .load_data (bus.mem_read),
        .pop       (bus.data_rsp_ready),
        .valid     (bus.data_rsp_valid),
        .data      (bus.data_rsp_data)
    );
endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb_memory_port_arbiter: vector table, corner sequences and randomized traffic against a reference model
module tb_memory_port_arbiter;
    import memory_port_arbiter_pkg::*;
    logic CLOCK = 1'b0;
    logic RESET;
    logic preload;
    memory_port_arbiter_if bus();
    memory_port_arbiter #(.DATA_FIRST(1'b1)) dut (.CLOCK(CLOCK), .RESET(RESET), .bus(bus.slave));
    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic rst, fv; DEFAULT_TYPE fa; logic frr, dv, dw; DEFAULT_TYPE da, dd; logic drr;
    } ins_t;
    typedef struct {
        logic fr, dr; MEMORY_FLAG_TYPE ctrl; DEFAULT_TYPE addr, wr;
        logic fv; DEFAULT_TYPE fd; logic dv; DEFAULT_TYPE dd;
    } outs_t;
    typedef struct { ins_t i; outs_t o; } vec_t;

    function automatic DEFAULT_TYPE init_byte(int i);
        return i == 'h00 ? 8'h11 : i == 'h20 ? 8'h22 : DEFAULT_TYPE'(i) ^ 8'h5A;
    endfunction

    // behavioural memory_unit: write on WRITE, registered read data on READ
    DEFAULT_TYPE mem [MEMSIZE];
    DEFAULT_TYPE mem_q;
    always @(posedge CLOCK) begin
        if (preload) begin
            for (int i = 0; i < MEMSIZE; i++) mem[i] <= init_byte(i);
            mem_q <= '0;
        end else begin
            if (bus.mem_ctrl == MEMORY_WRITE) mem[bus.mem_addr] <= bus.mem_write;
            if (bus.mem_ctrl == MEMORY_READ) mem_q <= mem[bus.mem_addr];
        end
    end
    assign bus.mem_read = mem_q;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // reference model: per port "busy" from issue until pop, response visible 2 cycles after issue
    DEFAULT_TYPE ref_mem [MEMSIZE];
    bit          m_busy [2];
    int          m_issue [2];
    DEFAULT_TYPE m_val [2];
    bit          m_last_data;

    function automatic ins_t mk_i(int rst, int fv, int fa, int frr, int dv, int dw, int da, int dd, int drr);
        ins_t x;
        x.rst = rst[0]; x.fv = fv[0]; x.fa = fa[7:0]; x.frr = frr[0];
        x.dv = dv[0]; x.dw = dw[0]; x.da = da[7:0]; x.dd = dd[7:0]; x.drr = drr[0];
        return x;
    endfunction

    function automatic outs_t mk_o(int fr, int dr, MEMORY_FLAG_TYPE ctrl, int addr, int wr, int fv, int fd, int dv, int dd);
        outs_t o;
        o.fr = fr[0]; o.dr = dr[0]; o.ctrl = ctrl; o.addr = addr[7:0]; o.wr = wr[7:0];
        o.fv = fv[0]; o.fd = fd[7:0]; o.dv = dv[0]; o.dd = dd[7:0];
        return o;
    endfunction

    task automatic model_expect(input ins_t x, output outs_t e);
        bit ef, ed, gf, gd;
        ef = !x.rst && x.fv && !m_busy[0];
        ed = !x.rst && x.dv && (x.dw || !m_busy[1]);
        gd = ed && (!ef || !m_last_data);
        gf = ef && !gd;
        e.fr = gf;
        e.dr = gd;
        e.ctrl = (gf || (gd && !x.dw)) ? MEMORY_READ : gd ? MEMORY_WRITE : MEMORY_NONE;
        e.addr = gd ? x.da : gf ? x.fa : 8'h00;
        e.wr = (gd && x.dw) ? x.dd : 8'h00;
        e.fv = m_busy[0] && cyc >= m_issue[0] + 2;
        e.fd = m_val[0];
        e.dv = m_busy[1] && cyc >= m_issue[1] + 2;
        e.dd = m_val[1];
    endtask

    task automatic model_update(input ins_t x, input outs_t e);
        if (x.rst) begin
            m_busy[0] = 0; m_busy[1] = 0; m_last_data = 0;
        end else begin
            if (e.fv && x.frr) m_busy[0] = 0;
            if (e.dv && x.drr) m_busy[1] = 0;
            if (e.dr && x.dw) ref_mem[x.da] = x.dd;
            if (e.dr && !x.dw) begin m_busy[1] = 1; m_issue[1] = cyc; m_val[1] = ref_mem[x.da]; end
            if (e.fr) begin m_busy[0] = 1; m_issue[0] = cyc; m_val[0] = ref_mem[x.fa]; end
            if (e.dr) m_last_data = 1;
            if (e.fr) m_last_data = 0;
        end
        cyc++;
    endtask

    task automatic chk(input string tag, input string n, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s.%s cyc=%0d got=%0h want=%0h", tag, n, cyc, act, exp);
        end
    endtask

    task automatic compare(input outs_t e, input string tag);
        chk(tag, "fetch_req_ready", int'(bus.fetch_req_ready), int'(e.fr));
        chk(tag, "data_req_ready", int'(bus.data_req_ready), int'(e.dr));
        chk(tag, "mem_ctrl", int'(bus.mem_ctrl), int'(e.ctrl));
        chk(tag, "mem_addr", int'(bus.mem_addr), int'(e.addr));
        chk(tag, "mem_write", int'(bus.mem_write), int'(e.wr));
        chk(tag, "fetch_rsp_valid", int'(bus.fetch_rsp_valid), int'(e.fv));
        if (e.fv) chk(tag, "fetch_rsp_data", int'(bus.fetch_rsp_data), int'(e.fd));
        chk(tag, "data_rsp_valid", int'(bus.data_rsp_valid), int'(e.dv));
        if (e.dv) chk(tag, "data_rsp_data", int'(bus.data_rsp_data), int'(e.dd));
    endtask

    task automatic step(input ins_t x, input outs_t want, input bit use_tbl, input string tag);
        outs_t e;
        @(posedge CLOCK);
        #1;
        RESET = x.rst;
        bus.fetch_req_valid = x.fv; bus.fetch_addr = x.fa; bus.fetch_rsp_ready = x.frr;
        bus.data_req_valid = x.dv; bus.data_req_write = x.dw; bus.data_addr = x.da;
        bus.data_wdata = x.dd; bus.data_rsp_ready = x.drr;
        model_expect(x, e);
        @(negedge CLOCK);
        if (use_tbl) compare(want, tag);
        else compare(e, tag);
        model_update(x, e);
    endtask

    vec_t vecs[$];
    task automatic add(input ins_t i, input outs_t o);
        vec_t v;
        v.i = i; v.o = o;
        vecs.push_back(v);
    endtask

    initial begin
        ins_t  idle, both, r;
        outs_t zero;
        for (int i = 0; i < MEMSIZE; i++) ref_mem[i] = init_byte(i);
        m_busy[0] = 0; m_busy[1] = 0; m_last_data = 0;
        m_issue[0] = 0; m_issue[1] = 0; m_val[0] = '0; m_val[1] = '0;
        RESET = 1'b1; preload = 1'b1;
        bus.fetch_req_valid = 0; bus.fetch_addr = '0; bus.fetch_rsp_ready = 0;
        bus.data_req_valid = 0; bus.data_req_write = 0; bus.data_addr = '0;
        bus.data_wdata = '0; bus.data_rsp_ready = 0;
        repeat (2) @(posedge CLOCK);
        #1 preload = 1'b0;

        idle = mk_i(0, 0, 0, 1, 0, 0, 0, 0, 1);
        both = mk_i(0, 1, 'h00, 1, 1, 0, 'h20, 0, 1);
        zero = mk_o(0, 0, MEMORY_NONE, 0, 0, 0, 0, 0, 0);
        // reset, then idle with rsp_ready high while empty
        add(mk_i(1, 0, 0, 0, 0, 0, 0, 0, 0), zero);
        for (int k = 0; k < 5; k++) add(idle, zero);
        // write 0x10<-0xA5 then read it back on the data port
        add(mk_i(0, 0, 0, 1, 1, 1, 'h10, 'hA5, 1), mk_o(0, 1, MEMORY_WRITE, 'h10, 'hA5, 0, 0, 0, 0));
        add(mk_i(0, 0, 0, 1, 1, 0, 'h10, 0, 1), mk_o(0, 1, MEMORY_READ, 'h10, 0, 0, 0, 0, 0));
        add(idle, zero);
        add(idle, mk_o(0, 0, MEMORY_NONE, 0, 0, 0, 0, 1, 'hA5));
        add(idle, zero);
        // both ports reading continuously after reset: data first, then alternation
        add(mk_i(1, 0, 0, 0, 0, 0, 0, 0, 0), zero);
        add(both, mk_o(0, 1, MEMORY_READ, 'h20, 0, 0, 0, 0, 0));
        add(both, mk_o(1, 0, MEMORY_READ, 'h00, 0, 0, 0, 0, 0));
        add(both, mk_o(0, 0, MEMORY_NONE, 0, 0, 0, 0, 1, 'h22));
        add(both, mk_o(0, 1, MEMORY_READ, 'h20, 0, 1, 'h11, 0, 0));
        add(both, mk_o(1, 0, MEMORY_READ, 'h00, 0, 0, 0, 0, 0));
        add(both, mk_o(0, 0, MEMORY_NONE, 0, 0, 0, 0, 1, 'h22));
        add(both, mk_o(0, 1, MEMORY_READ, 'h20, 0, 1, 'h11, 0, 0));
        add(idle, zero);
        add(idle, mk_o(0, 0, MEMORY_NONE, 0, 0, 0, 0, 1, 'h22));
        add(idle, zero);
        // write 0x30<-0x7E immediately followed by fetch read of 0x30
        add(mk_i(0, 0, 0, 1, 1, 1, 'h30, 'h7E, 1), mk_o(0, 1, MEMORY_WRITE, 'h30, 'h7E, 0, 0, 0, 0));
        add(mk_i(0, 1, 'h30, 1, 0, 0, 0, 0, 1), mk_o(1, 0, MEMORY_READ, 'h30, 0, 0, 0, 0, 0));
        add(idle, zero);
        add(idle, mk_o(0, 0, MEMORY_NONE, 0, 0, 1, 'h7E, 0, 0));
        add(idle, zero);
        foreach (vecs[k]) step(vecs[k].i, vecs[k].o, 1, "vec");

        // fetch backpressure: slot held, fetch blocked, writes still stream
        step(mk_i(0, 1, 'h00, 0, 0, 0, 0, 0, 0), mk_o(1, 0, MEMORY_READ, 'h00, 0, 0, 0, 0, 0), 1, "bp_issue");
        step(mk_i(0, 1, 'h00, 0, 0, 0, 0, 0, 0), zero, 1, "bp_pend");
        for (int k = 0; k < 5; k++)
            step(mk_i(0, 1, 'h00, 0, 1, 1, 'h40 + k, 'h60 + k, 0),
                 mk_o(0, 1, MEMORY_WRITE, 'h40 + k, 'h60 + k, 1, 'h11, 0, 0), 1, "bp_hold");
        step(mk_i(0, 1, 'h00, 1, 0, 0, 0, 0, 0), mk_o(0, 0, MEMORY_NONE, 0, 0, 1, 'h11, 0, 0), 1, "bp_pop");
        step(mk_i(0, 1, 'h00, 1, 0, 0, 0, 0, 0), mk_o(1, 0, MEMORY_READ, 'h00, 0, 0, 0, 0, 0), 1, "bp_reissue");
        step(idle, zero, 1, "bp_drain");
        step(idle, mk_o(0, 0, MEMORY_NONE, 0, 0, 1, 'h11, 0, 0), 1, "bp_last");

        // reset the cycle after a fetch handshake discards it
        step(mk_i(0, 1, 'h00, 1, 0, 0, 0, 0, 1), mk_o(1, 0, MEMORY_READ, 'h00, 0, 0, 0, 0, 0), 1, "rst_issue");
        step(mk_i(1, 0, 0, 1, 0, 0, 0, 0, 1), zero, 1, "rst_assert");
        for (int k = 0; k < 4; k++) step(idle, zero, 1, "rst_nodata");
        // data granted last, then reset: first conflict must still go to data
        step(mk_i(0, 0, 0, 1, 1, 1, 'h50, 'h33, 1), mk_o(0, 1, MEMORY_WRITE, 'h50, 'h33, 0, 0, 0, 0), 1, "rst_w");
        step(mk_i(1, 0, 0, 0, 0, 0, 0, 0, 0), zero, 1, "rst2");
        step(both, mk_o(0, 1, MEMORY_READ, 'h20, 0, 0, 0, 0, 0), 1, "rst_first");
        step(idle, zero, 1, "rst_cap");
        step(idle, mk_o(0, 0, MEMORY_NONE, 0, 0, 0, 0, 1, 'h22), 1, "rst_rsp");

        // randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            r.rst = n == 0 || $urandom_range(0, 39) == 0;
            r.fv  = 1'($urandom_range(0, 1));
            r.fa  = DEFAULT_TYPE'($urandom_range(0, 7) * 16);
            r.frr = $urandom_range(0, 9) < 7;
            r.dv  = 1'($urandom_range(0, 1));
            r.dw  = 1'($urandom_range(0, 1));
            r.da  = DEFAULT_TYPE'($urandom_range(0, 7) * 16);
            r.dd  = DEFAULT_TYPE'($urandom_range(0, 255));
            r.drr = $urandom_range(0, 9) < 7;
            step(r, zero, 0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Two-port front end for the single-port `memory_unit`: arbitrates between the instruction-fetch port (read-only) and the load/store data port (read/write). It drives the memory's control/address/write buses and captures its one-cycle-late read data into per-port response slots with valid/ready backpressure. It sits directly upstream of `memory_unit`, between it and the CPU state machine.

## Interface
- `DATA_FIRST`, default 1: which port wins the first conflict after reset (1 = data, 0 = fetch).

Clock and reset are fixed for this block: one clock `CLOCK`; reset `RESET` is synchronous and active-high.

- `CLOCK`  in  1  sole clock; all state updates on posedge.
- `RESET`  in  1  synchronous, active-high.
- `fetch_req_valid`  in  1  fetch read request.
- `fetch_req_ready`  out  1  fetch request accepted this cycle when high together with `fetch_req_valid`.
- `fetch_addr`  in  DEFAULT_TYPE  fetch address.
- `fetch_rsp_valid`  out  1  fetch response slot full.
- `fetch_rsp_ready`  in  1  consumer pops fetch response.
- `fetch_rsp_data`  out  DEFAULT_TYPE  fetched byte.
- `data_req_valid`  in  1  data request.
- `data_req_ready`  out  1  data request accepted.
- `data_req_write`  in  1  1 = write, 0 = read.
- `data_addr`  in  DEFAULT_TYPE  data address.
- `data_wdata`  in  DEFAULT_TYPE  write byte.
- `data_rsp_valid`  out  1  data read response slot full.
- `data_rsp_ready`  in  1  consumer pops data response.
- `data_rsp_data`  out  DEFAULT_TYPE  read byte.
- `mem_ctrl`  out  MEMORY_FLAG_TYPE  to memory `ctrl_bus`.
- `mem_addr`  out  DEFAULT_TYPE  to memory `addr_bus`.
- `mem_write`  out  DEFAULT_TYPE  to memory `write_bus`.
- `mem_read`  in  DEFAULT_TYPE  from memory `read_bus`; valid the cycle after the address is presented.

## Operation
- Eligibility:
  - A read on port P is eligible when P has no read in flight and P's response slot is empty.
  - A data write is always eligible and produces no response.
- Grant (combinational):
  - At most one eligible request is granted per cycle.
  - Single eligible request: it wins.
  - Two eligible requests: the port not granted last wins (round-robin). The `last_grant` register updates on every handshake.
  - `req_ready` is high only for the granted port.
- Memory drive in the grant cycle:
  - Data write: `mem_ctrl`=MEMORY_WRITE, `mem_addr`=`data_addr`, `mem_write`=`data_wdata`.
  - Read: `mem_ctrl`=MEMORY_READ, `mem_addr` = that port's address.
  - No grant: `mem_ctrl`=MEMORY_NONE, `mem_addr`=0, `mem_write`=0.
  - `mem_write`=0 whenever no write is granted.
- In-flight tracker: `pend_valid`, `pend_port`. Set at the read handshake edge. At the next edge, `mem_read` is written into slot[`pend_port`] and pend clears, unless a new read is granted in the same cycle (then pend reloads).
- Response slot:
  - Full flag plus data register.
  - Pop when `rsp_valid & rsp_ready`.
  - Eligibility requires an empty slot, so a capture never collides with a full slot.
- Ordering: strictly in issue order. A read issued the cycle after a write to the same address returns the new value.
- Reset:
  - All outputs are 0 / MEMORY_NONE.
  - `rsp_valid` is 0 and `pend_valid` is 0.
  - `last_grant` is set so that the port selected by `DATA_FIRST` wins the first conflict.
  - A read in flight when reset asserts is discarded and produces no response.

## Timing
- Read latency: handshake in cycle N, address latched by memory at end of N, captured at end of N+1, `rsp_valid`=1 in cycle N+2.
- Throughput: one memory access per cycle across both ports.
- Per-port read rate: one read per 3 cycles while the consumer holds `rsp_ready`=1 (in flight → slot full → popped). Writes are back-to-back at 1/cycle.
- `rsp_valid` and `rsp_data` are held stable until popped.
- `rsp_ready` while empty has no effect.
- Pop and new-request eligibility: a slot popped in cycle K makes that port eligible in cycle K+1, not K.

## Structure
- Shared package `typedef_collection.sv` holds:
  - `DEFAULT_TYPE` (logic [7:0]).
  - `MEMORY_FLAG_TYPE` enum {MEMORY_NONE, MEMORY_READ, MEMORY_WRITE}.
  - `` `MEMSIZE ``.
  - New enum `MEMORY_PORT_TYPE` {PORT_FETCH, PORT_DATA}, used for `pend_port` and `last_grant`.
- Sub-module `memory_response_slot`: one-entry valid/data register with load and pop, instantiated twice.

## Test plan
- Reset then idle → all `rsp_valid`=0, `mem_ctrl`=MEMORY_NONE, `mem_addr`=0 for 5 cycles.
- Data write addr 0x10 data 0xA5 in cycle 0, data read 0x10 in cycle 1, `rsp_ready`=1 → `data_rsp_valid`=1 with 0xA5 in cycle 3.
- Both ports request reads (fetch 0x00, data 0x20) every cycle with `DATA_FIRST`=1 → grants alternate data, fetch, data…; each response returns its own port's byte (preloaded 0x11 @0x00, 0x22 @0x20).
- `fetch_rsp_ready`=0 after one fetch read → `fetch_req_ready` stays 0 and `fetch_rsp_data` holds. Data writes still pass at 1/cycle.
- `RESET` asserted in the cycle after a fetch read handshake → no `fetch_rsp_valid` ever appears; first post-reset conflict goes to data.
- Data write 0x30←0x7E followed immediately by fetch read 0x30 → fetch response 0x7E.
